// File: rtl/dshot_pkg.sv
// Shared DShot definitions: frame geometry, transmitter state encoding and
// the 4-bit frame checksum.
package dshot_pkg;

    localparam int DSHOT_FRAME_W   = 16;
    localparam int DSHOT_THR_W     = 11;
    localparam int DSHOT_CRC_W     = 4;
    localparam int DSHOT_PAYLOAD_W = DSHOT_THR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } dshot_state_e;

    // XOR of the three payload nibbles {throttle, telemetry}.
    function automatic logic [DSHOT_CRC_W-1:0] dshot_crc(input logic [DSHOT_PAYLOAD_W-1:0] v);
        logic [DSHOT_PAYLOAD_W-1:0] x;
        x = v ^ (v >> 4) ^ (v >> 8);
        return x[DSHOT_CRC_W-1:0];
    endfunction

endpackage

// File: rtl/dshot_tx_if.sv
// Frame request handshake and serial pin of the DShot transmitter.
interface dshot_tx_if
    import dshot_pkg::*;
;
    logic [DSHOT_THR_W-1:0] throttle;
    logic                   telemetry;
    logic                   valid;
    logic                   ready;
    logic                   busy;
    logic                   dshotPin;

    modport master (
        output throttle, telemetry, valid,
        input  ready, busy, dshotPin
    );

    modport slave (
        input  throttle, telemetry, valid,
        output ready, busy, dshotPin
    );
endinterface

// File: rtl/dshot_tx.sv
// DShot frame transmitter: latches {throttle, telemetry}, appends the CRC and
// shifts the 16-bit frame out MSB first as pulse-width-coded bits.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a frame, pin low
//   SEND  | serialising bit bit_q, cnt_q = cycle within the bit
//   GAP   | mandatory low time after the frame, gap_q counts down to 0
module dshot_tx
    import dshot_pkg::*;
#(
    parameter int BIT_CYCLES = 107,
    parameter int T1H_CYCLES = 80,
    parameter int T0H_CYCLES = 40,
    parameter int GAP_CYCLES = 32
) (
    input  logic      clk,
    input  logic      rst,
    dshot_tx_if.slave bus
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(T1H_CYCLES);
    localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(T0H_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    if (!((T0H_CYCLES > 0) && (T0H_CYCLES < T1H_CYCLES) && (T1H_CYCLES < BIT_CYCLES))) begin : g_bad_pulse
        $error("dshot_tx: need 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("dshot_tx: GAP_CYCLES must be at least 1");
    end

    dshot_state_e               state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [3:0]                 bit_q, bit_d;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic [DSHOT_FRAME_W-1:0]   frame_q, frame_d;
    logic                       pin_q, pin_d;
    logic [DSHOT_PAYLOAD_W-1:0] payload;
    logic [CNT_W-1:0]           high_lim;
    logic                       accept;

    assign payload = {bus.throttle, bus.telemetry};
    assign accept  = bus.valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        frame_d = frame_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    frame_d = {payload, dshot_crc(payload)};
                    bit_d   = 4'd15;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 4'd0) begin
                        state_d = GAP;
                        gap_d   = GAP_LAST;
                    end else begin
                        bit_d = bit_q - 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin is decoded from the next state so the registered output shows the
    // first high cycle of bit 15 on the same edge that accepts the frame.
    always_comb begin
        high_lim = frame_d[bit_d] ? T1H_C : T0H_C;
        pin_d    = (state_d == SEND) && (cnt_d < high_lim);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            frame_q <= '0;
            pin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            frame_q <= frame_d;
            pin_q   <= pin_d;
        end
    end

    assign bus.ready    = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.dshotPin = pin_q;

endmodule

// File: tb/tb_dshot_tx.sv
// Bench for dshot_tx: timeline model of the pin/ready/busy waveform checked
// every cycle, plus pulse-width decoding of each frame against literal words.
module tb_dshot_tx;

    localparam int B         = 107;
    localparam int T1H       = 80;
    localparam int T0H       = 40;
    localparam int G         = 32;
    localparam int FRAME_CYC = 16 * B;
    localparam int BUSY_CYC  = FRAME_CYC + G;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dshot_tx_if bus ();

    dshot_tx #(
        .BIT_CYCLES(B),
        .T1H_CYCLES(T1H),
        .T0H_CYCLES(T0H),
        .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame accepted on edge S occupies edges S .. S+BUSY_CYC-1.
    int          e       = 0;
    bit          m_have  = 0;
    int          m_start = 0;
    int          m_frame = 0;
    int          m_acc_e = -1;

    function automatic int model_frame(input int thr, input int tel);
        int v;
        int crc;
        v   = thr * 2 + tel;
        crc = (v ^ (v >> 4) ^ (v >> 8)) & 15;
        return v * 16 + crc;
    endfunction

    function automatic bit m_busy_at(input int k);
        int d;
        d = k - m_start;
        return m_have && (d >= 0) && (d < BUSY_CYC);
    endfunction

    function automatic bit m_pin_at(input int k);
        int d;
        int b;
        d = k - m_start;
        if (!m_have || d < 0 || d >= FRAME_CYC) return 1'b0;
        b = (m_frame >> (15 - d / B)) & 1;
        return (d % B) < (b != 0 ? T1H : T0H);
    endfunction

    always @(posedge clk) begin
        e = e + 1;
        if (rst) begin
            m_have = 0;
        end else if (bus.valid && !m_busy_at(e - 1)) begin
            m_have  = 1;
            m_start = e;
            m_frame = model_frame(int'(bus.throttle), int'(bus.telemetry));
            m_acc_e = e;
        end
    end

    always @(negedge clk) begin
        if (e > 0) begin
            chk("pin",   bus.dshotPin, m_pin_at(e));
            chk("ready", bus.ready,    !m_busy_at(e));
            chk("busy",  bus.busy,     m_busy_at(e));
        end
    end

    // ---------------- pulse monitor ----------------
    logic prev_pin = 1'b0;
    int   rise_e   = 0;
    int   widths[$];
    int   rises[$];

    always @(negedge clk) begin
        if (bus.dshotPin === 1'b1 && prev_pin === 1'b0) begin
            rise_e = e;
            rises.push_back(e);
        end
        if (bus.dshotPin === 1'b0 && prev_pin === 1'b1) widths.push_back(e - rise_e);
        prev_pin = bus.dshotPin;
    end

    task automatic decode(input int base, input string name, input logic [15:0] exp);
        logic [15:0] w;
        int          bad_w;
        int          bad_p;
        w     = '0;
        bad_w = 0;
        bad_p = 0;
        if (widths.size() < base + 16 || rises.size() < base + 16) begin
            chk({name, "_pulse_count"}, widths.size(), base + 16);
        end else begin
            for (int i = 0; i < 16; i++) begin
                w = {w[14:0], widths[base + i] == T1H};
                if (widths[base + i] != T1H && widths[base + i] != T0H) bad_w++;
                if (i > 0 && rises[base + i] - rises[base + i - 1] != B) bad_p++;
            end
            chk({name, "_word"}, w, exp);
            chk({name, "_bad_widths"}, bad_w, 0);
            chk({name, "_bad_periods"}, bad_p, 0);
        end
    endtask

    task automatic send(input int thr, input int tel, input bit hold);
        bit got;
        got           = 0;
        bus.throttle  = 11'(thr);
        bus.telemetry = tel[0];
        bus.valid     = 1'b1;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(posedge clk);
            #1;
            if (m_acc_e == e) got = 1;
        end
        if (!got) chk("accept_timeout", 0, 1);
        if (!hold) bus.valid = 1'b0;
    endtask

    task automatic wait_ready(output int r);
        r = -1;
        for (int i = 0; i < 4000 && r < 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready === 1'b1) r = e;
        end
        if (r < 0) chk("ready_timeout", 0, 1);
    endtask

    task automatic clear_mon();
        widths.delete();
        rises.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int a1;
        int a2;
        int r;
        bus.throttle  = '0;
        bus.telemetry = 1'b0;
        bus.valid     = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_pin",   bus.dshotPin, 0);
        chk("reset_ready", bus.ready,    1);
        chk("reset_busy",  bus.busy,     0);

        chk("model_crc_0",    model_frame(0, 0),    32'h0000);
        chk("model_crc_48",   model_frame(48, 0),   32'h0606);
        chk("model_crc_1046", model_frame(1046, 1), 32'h82D7);
        chk("model_crc_2047", model_frame(2047, 1), 32'hFFFF);

        // Disarmed frame, latency from the accept cycle to ready returning.
        clear_mon();
        send(0, 0, 0);
        acc = m_acc_e;
        wait_ready(r);
        chk("t0_ready_latency", r - acc + 1, 1745);
        decode(0, "t0", 16'h0000);

        clear_mon();
        send(48, 0, 0);
        wait_ready(r);
        decode(0, "t48", 16'h0606);

        clear_mon();
        send(1046, 1, 0);
        wait_ready(r);
        decode(0, "t1046", 16'h82D7);

        clear_mon();
        send(2047, 1, 0);
        wait_ready(r);
        decode(0, "t2047", 16'hFFFF);

        // Back-to-back with valid held; inputs and valid wiggle while busy.
        clear_mon();
        send(48, 0, 1);
        a1 = m_acc_e;
        repeat (100) @(posedge clk);
        #1;
        bus.throttle  = 11'd1046;
        bus.telemetry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.valid = ~bus.valid;
            repeat (50) @(posedge clk);
            #1;
        end
        a2 = a1;
        for (int i = 0; i < 4000 && a2 == a1; i++) begin
            @(posedge clk);
            #1;
            if (m_acc_e != a1) a2 = m_acc_e;
        end
        bus.valid = 1'b0;
        chk("b2b_accept_period", a2 - a1, 1745);
        wait_ready(r);
        decode(0,  "b2b_f1", 16'h0606);
        decode(16, "b2b_f2", 16'h82D7);
        if (rises.size() >= 17) chk("b2b_rise_period", rises[16] - rises[0], 1745);
        else chk("b2b_rise_count", rises.size(), 32);

        // Reset during bit 7 while the pin is high.
        send(2047, 1, 0);
        acc = m_acc_e;
        for (int i = 0; i < 4000 && e < acc + 8 * B + 10; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_mid_pin_before", bus.dshotPin, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_pin",   bus.dshotPin, 0);
        chk("rst_mid_ready", bus.ready,    1);
        chk("rst_mid_busy",  bus.busy,     0);
        @(negedge clk);
        #1;
        clear_mon();
        send(0, 0, 0);
        wait_ready(r);
        decode(0, "post_rst", 16'h0000);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
